// File: rtl/score_keeper_pkg.sv
// rtl/score_keeper_pkg.sv - shared state encodings, register addresses and BCD compare helper
package score_keeper_pkg;

  typedef enum logic [2:0] {
    IDLE_S    = 3'd0,
    PLAYING_S = 3'd1,
    HIT_S     = 3'd2,
    PAUSED_S  = 3'd3,
    OVER_S    = 3'd4
  } state_t;

  localparam int REG_HIGH   = 0;
  localparam int REG_PLAYED = 1;
  localparam int REG_LAST   = 2;
  localparam int REG_LIVES  = 3;

  // Digit-wise compare, tens first; the packed byte orders the same way
  function automatic logic bcd_gt(input logic [3:0] a_tens, input logic [3:0] a_ones,
                                  input logic [3:0] b_tens, input logic [3:0] b_ones);
    return (a_tens > b_tens) || ((a_tens == b_tens) && (a_ones > b_ones));
  endfunction

endpackage

// File: rtl/score_bcd_counter.sv
// rtl/score_bcd_counter.sv - two-digit saturating BCD incrementer with synchronous clear
module score_bcd_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic at_max;
  assign at_max = (tens == 4'd9) && (ones == 4'd9);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc && !at_max) begin
      if (ones == 4'd9) begin
        ones <= 4'd0;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - game score/lives tracker with game-over commit into a 32x8 register file
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int C_LIVES_INI = 3,
  parameter int C_DEPTH     = 32,
  parameter int C_ADDR_BITS = 5,
  parameter int C_DATA_BITS = 8
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Game_Active,
  input  logic                   i_Has_Collided,
  input  logic                   i_Level_Up,
  input  logic                   i_write_en,
  input  logic [C_ADDR_BITS-1:0] i_write_addr,
  input  logic [C_DATA_BITS-1:0] i_write_data,
  input  logic                   i_read_en,
  input  logic [C_ADDR_BITS-1:0] i_read_addr,
  output logic [C_DATA_BITS-1:0] o_read_data,
  output logic                   o_read_valid,
  output logic [3:0]             o_Score_Tens,
  output logic [3:0]             o_Score_Ones,
  output logic [1:0]             o_Lives,
  output logic                   o_Game_Over,
  output logic                   o_New_High
);

  state_t                 state;
  logic [1:0]             lives;
  logic [C_DATA_BITS-1:0] regs [C_DEPTH];

  logic [1:0] lives_cfg;
  logic [1:0] start_lives;
  logic       score_clear;
  logic       score_inc;
  logic [7:0] score_packed;
  logic       beats_high;
  logic       commit_blocks_write;

  assign lives_cfg    = regs[REG_LIVES][1:0];
  assign start_lives  = (lives_cfg == 2'd0) ? 2'd1 : lives_cfg;
  assign score_clear  = (state == IDLE_S) && i_Game_Active;
  // A collision in the same cycle swallows the level-up
  assign score_inc    = (state == PLAYING_S) && i_Level_Up && !i_Has_Collided;
  assign score_packed = {o_Score_Tens, o_Score_Ones};
  assign beats_high   = bcd_gt(o_Score_Tens, o_Score_Ones,
                               regs[REG_HIGH][7:4], regs[REG_HIGH][3:0]);
  assign commit_blocks_write = (state == OVER_S) && (int'(i_write_addr) <= REG_LAST);

  score_bcd_counter u_score (
    .clk   (i_Clk),
    .reset (i_Reset),
    .clear (score_clear),
    .inc   (score_inc),
    .tens  (o_Score_Tens),
    .ones  (o_Score_Ones)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state       <= IDLE_S;
      lives       <= 2'(C_LIVES_INI);
      o_Game_Over <= 1'b0;
      o_New_High  <= 1'b0;
    end else begin
      o_Game_Over <= 1'b0;
      o_New_High  <= 1'b0;
      case (state)
        IDLE_S: begin
          if (i_Game_Active) begin
            state <= PLAYING_S;
            lives <= start_lives;
          end
        end
        PLAYING_S: begin
          if (i_Has_Collided) begin
            lives <= lives - 2'd1;
            state <= HIT_S;
          end
        end
        HIT_S: begin
          if (!i_Has_Collided) begin
            state <= (lives == 2'd0) ? OVER_S : PAUSED_S;
          end
        end
        PAUSED_S: begin
          if (i_Game_Active) begin
            state <= PLAYING_S;
          end
        end
        OVER_S: begin
          o_Game_Over <= 1'b1;
          o_New_High  <= beats_high;
          state       <= IDLE_S;
        end
        default: state <= IDLE_S;
      endcase
    end
  end

  assign o_Lives = lives;

  // Commit writes come after the external write so they win on regs 0-2
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int i = 0; i < C_DEPTH; i++) begin
        regs[i] <= (i == REG_LIVES) ? C_DATA_BITS'(C_LIVES_INI) : '0;
      end
    end else begin
      if (i_write_en && !commit_blocks_write) begin
        regs[i_write_addr] <= i_write_data;
      end
      if (state == OVER_S) begin
        regs[REG_LAST] <= score_packed;
        if (regs[REG_PLAYED] != 8'hFF) begin
          regs[REG_PLAYED] <= regs[REG_PLAYED] + 8'd1;
        end
        if (beats_high) begin
          regs[REG_HIGH] <= score_packed;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_read_valid <= 1'b0;
      o_read_data  <= '0;
    end else begin
      o_read_valid <= i_read_en;
      if (i_read_en) begin
        o_read_data <= regs[i_read_addr];
      end
    end
  end

endmodule
